// File: rtl/regfile_n_pkg.sv
// regfile_n_pkg: shared helpers for the regfile_n register bank.
//   addr_width(depth) - address width used for the write/read address ports.
package regfile_n_pkg;

   // Width of an address able to reach every entry. Never below 1, so the
   // address ports stay legal even for degenerate depths.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_n_register_n.sv
// register_n: one N-bit register with synchronous active-high clear and
// write enable. Used as a single entry of the regfile_n bank.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; clears q, dominates en
//   en     - load d into q at the next rising edge
//   d      - data in  [N-1:0]
//   q      - data out [N-1:0]
module register_n #(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile_n.sv
// regfile_n: DEPTH x WIDTH register file with one synchronous write port,
// NUM_RD combinational read ports with write-to-read bypass, and a
// synchronous clear of every entry.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous, active-high; clears all entries, forces reads to 0
//   wr_en    - write enable
//   wr_addr  - write address [AW-1:0]
//   wr_data  - write data [WIDTH-1:0]
//   rd_addr  - packed read addresses; port k at rd_addr[k*AW +: AW]
//   rd_data  - packed read data;      port k at rd_data[k*WIDTH +: WIDTH]
// Writes to addresses >= DEPTH are dropped; reads of them return 0. With
// ZERO_REG=1 entry 0 reads as 0 and is not built.
module regfile_n
   import regfile_n_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NUM_RD   = 2,
   parameter bit          ZERO_REG = 1'b1,
   localparam int unsigned AW      = addr_width(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_addr,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*WIDTH-1:0] rd_data
);

   // One extra bit so DEPTH itself is representable (e.g. DEPTH=32, AW=5).
   localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] entry [DEPTH];
   logic             wr_ok;

   function automatic logic in_range(input logic [AW-1:0] addr);
      return {1'b0, addr} < DEPTH_EXT;
   endfunction

   // A write is real only if it will land in storage; the bypass uses the
   // same qualifier so a dropped write is never forwarded.
   always_comb begin
      wr_ok = wr_en && !reset && in_range(wr_addr) && !(ZERO_REG && (wr_addr == '0));
   end

   // Storage plus one-hot write decode, distributed per entry.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if (ZERO_REG && (i == 0)) begin : g_zero
         assign entry[i] = '0;
      end else begin : g_reg
         logic sel;
         assign sel = wr_ok && (wr_addr == AW'(i));

         register_n #(
            .N (WIDTH)
         ) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (sel),
            .d     (wr_data),
            .q     (entry[i])
         );
      end
   end

   // Read ports: independent mux + bypass compare per port.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] rv;

      assign ra = rd_addr[k*AW +: AW];

      always_comb begin
         if (reset) begin
            rv = '0;
         end else if (!in_range(ra)) begin
            rv = '0;
         end else if (ZERO_REG && (ra == '0)) begin
            rv = '0;
         end else if (wr_ok && (wr_addr == ra)) begin
            rv = wr_data;
         end else begin
            rv = entry[ra];
         end
      end

      assign rd_data[k*WIDTH +: WIDTH] = rv;
   end

endmodule

// File: tb/tb_regfile_n.sv
// tb_regfile_n: directed bench for regfile_n. Three instances share one
// stimulus stream: A (DEPTH=32, ZERO_REG=1), B (DEPTH=32, ZERO_REG=0) and
// C (DEPTH=12, ZERO_REG=1, low 4 address bits). Expected read data comes
// from a behavioural model and goes through a scoreboard queue.
module tb_regfile_n;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  ra0, ra1;
   logic [63:0] rd_a, rd_b, rd_c;

   always #5 clk = ~clk;

   regfile_n #(
      .WIDTH (32), .DEPTH (32), .NUM_RD (2), .ZERO_REG (1'b1)
   ) u_a (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr ({ra1, ra0}),
      .rd_data (rd_a)
   );

   regfile_n #(
      .WIDTH (32), .DEPTH (32), .NUM_RD (2), .ZERO_REG (1'b0)
   ) u_b (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr ({ra1, ra0}),
      .rd_data (rd_b)
   );

   regfile_n #(
      .WIDTH (32), .DEPTH (12), .NUM_RD (2), .ZERO_REG (1'b1)
   ) u_c (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr[3:0]),
      .wr_data (wr_data),
      .rd_addr ({ra1[3:0], ra0[3:0]}),
      .rd_data (rd_c)
   );

   // Behavioural model of the three arrays.
   logic [31:0] mem_a [32];
   logic [31:0] mem_b [32];
   logic [31:0] mem_c [12];

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q [$];
   int  vectors = 0;
   int  miscompares = 0;

   function automatic logic [31:0] model_rd(input int dut, input logic [4:0] ra);
      logic [4:0] a     = ra;
      logic [4:0] wa    = wr_addr;
      int         depth = 32;
      bit         zr    = (dut != 1);
      if (dut == 2) begin
         a     = {1'b0, ra[3:0]};
         wa    = {1'b0, wr_addr[3:0]};
         depth = 12;
      end
      if (reset) return 32'h0;
      if (int'(a) >= depth) return 32'h0;
      if (zr && (a == 5'd0)) return 32'h0;
      if (wr_en && (wa == a)) return wr_data;
      case (dut)
         0:       return mem_a[a];
         1:       return mem_b[a];
         default: return mem_c[a[3:0]];
      endcase
   endfunction

   // Advance one clock and apply the same edge to the model.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
         end
         for (int i = 0; i < 12; i++) mem_c[i] = 32'h0;
      end else if (wr_en) begin
         if (wr_addr != 5'd0) mem_a[wr_addr] = wr_data;
         mem_b[wr_addr] = wr_data;
         if ((wr_addr[3:0] != 4'd0) && (wr_addr[3:0] < 4'd12)) mem_c[wr_addr[3:0]] = wr_data;
      end
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   // Queue the expected value of every port, let the read paths settle,
   // then pop and compare in the same order.
   task automatic check(input string tag);
      logic [31:0] obs [6];
      sb_t         e;
      push($sformatf("%s a.p0@%0d", tag, ra0), model_rd(0, ra0));
      push($sformatf("%s a.p1@%0d", tag, ra1), model_rd(0, ra1));
      push($sformatf("%s b.p0@%0d", tag, ra0), model_rd(1, ra0));
      push($sformatf("%s b.p1@%0d", tag, ra1), model_rd(1, ra1));
      push($sformatf("%s c.p0@%0d", tag, ra0[3:0]), model_rd(2, ra0));
      push($sformatf("%s c.p1@%0d", tag, ra1[3:0]), model_rd(2, ra1));
      #1;
      obs[0] = rd_a[31:0];
      obs[1] = rd_a[63:32];
      obs[2] = rd_b[31:0];
      obs[3] = rd_b[63:32];
      obs[4] = rd_c[31:0];
      obs[5] = rd_c[63:32];
      for (int i = 0; i < 6; i++) begin
         e = sb_q.pop_front();
         vectors++;
         assert (obs[i] === e.exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs[i], e.exp);
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_addr = 5'd0;
      wr_data = 32'h0;
      ra0     = 5'd0;
      ra1     = 5'd0;
      tick();
      ra0 = 5'd5;
      ra1 = 5'd31;
      check("reset_hold");
      tick();

      // First cycle out of reset: everything reads 0.
      reset = 1'b0;
      check("post_reset");

      // Fill 1..31; port0 exercises bypass, port1 reads the previous entry.
      for (int i = 1; i < 32; i++) begin
         wr_en   = 1'b1;
         wr_addr = 5'(i);
         wr_data = 32'hDEADBEEF;
         ra0     = 5'(i);
         ra1     = 5'(i - 1);
         check("fill");
         tick();
      end

      // Reset dominates a same-cycle write; reads are 0 during reset.
      reset   = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 5'd3;
      wr_data = 32'h1;
      ra0     = 5'd3;
      ra1     = 5'd9;
      check("reset_vs_write");
      tick();
      reset = 1'b0;
      wr_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ra0 = 5'(i);
         ra1 = 5'(31 - i);
         check("clear_sweep");
         tick();
      end

      // Write then read back on both ports; neighbour untouched.
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'h12345678;
      tick();
      wr_en = 1'b0;
      ra0   = 5'd5;
      ra1   = 5'd5;
      check("readback");
      ra0 = 5'd6;
      check("neighbour");
      tick();

      // Preload entry 8, then same-cycle bypass on 7 while port1 reads 8.
      wr_en   = 1'b1;
      wr_addr = 5'd8;
      wr_data = 32'h0BADF00D;
      tick();
      wr_addr = 5'd7;
      wr_data = 32'hA5A5A5A5;
      ra0     = 5'd7;
      ra1     = 5'd8;
      check("bypass");
      tick();
      wr_en = 1'b0;
      check("bypass_stored");

      // Write to address 0: hardwired zero on A/C, real storage on B.
      wr_en   = 1'b1;
      wr_addr = 5'd0;
      wr_data = 32'hFFFFFFFF;
      ra0     = 5'd0;
      ra1     = 5'd0;
      check("zero_same");
      tick();
      wr_en = 1'b0;
      check("zero_later");

      // Address 13 is out of range for C (DEPTH=12).
      wr_en   = 1'b1;
      wr_addr = 5'd13;
      wr_data = 32'h55;
      ra0     = 5'd13;
      ra1     = 5'd11;
      check("oor_same");
      tick();
      wr_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ra0 = 5'(i);
         ra1 = 5'd13;
         check("oor_sweep");
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
